// File: rtl/vga_pkg.sv
// Shared constants for the VGA page renderers: screen size, 12-bit colours
// (blue-green-red nibble order), font ROM geometry and the per-pixel
// pipeline record used by the numeric overlay.
package vga_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int COLOR_W = 12;
    localparam logic [COLOR_W-1:0] COLOR_BLACK = 12'h000;
    localparam logic [COLOR_W-1:0] COLOR_RED   = 12'h00F;
    localparam logic [COLOR_W-1:0] COLOR_GREEN = 12'h0F0;
    localparam logic [COLOR_W-1:0] COLOR_BLUE  = 12'hF00;
    localparam logic [COLOR_W-1:0] COLOR_WHITE = 12'hFFF;

    // Number-font ROM: ten glyphs side by side, one ROM row per glyph row.
    localparam int FONT_GLYPH_W    = 32;
    localparam int FONT_GLYPH_H    = 64;
    localparam int FONT_ROW_STRIDE = 10 * FONT_GLYPH_W;
    localparam int FONT_AW         = 15;

    // Everything a pixel carries down the overlay pipeline besides the ROM bit.
    typedef struct packed {
        logic               inCell;
        logic               blank;
        logic               hl;
        logic [COLOR_W-1:0] bg;
    } overlay_flags_t;

endpackage

// File: rtl/digit_blank_mask.sv
// Decides which digit cells are drawn as background: disabled cells, non-BCD
// nibbles, and (optionally) leading zeros. The least significant cell is
// never treated as a leading zero so a value of 0 still shows one digit.
module digit_blank_mask
    import vga_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]   digit_en_i,
    output logic [N_DIGITS-1:0]   blank_o
);

    logic upperZero;

    // Walk from the most significant cell down, tracking whether every nibble so far is zero.
    always_comb begin
        upperZero = 1'b1;
        blank_o   = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            upperZero  = upperZero & (digits_i[4*i +: 4] == 4'd0);
            blank_o[i] = !digit_en_i[i]
                       || (digits_i[4*i +: 4] > 4'd9)
                       || ((LZ_SUPPRESS != 0) && (i > 0) && upperZero);
        end
    end

endmodule

// File: rtl/vga_digit_overlay.sv
// Draws a row of scaled number-font glyphs over the upstream background.
// Operands are frozen once per frame at scan position (0,0); the pixel path
// is three registers deep (address, ROM read, compose) so the sync generator
// only needs a fixed 3-cycle delay to stay aligned.
module vga_digit_overlay
    import vga_pkg::*;
#(
    parameter int              N_DIGITS     = 4,
    parameter int              GLYPH_W      = FONT_GLYPH_W,
    parameter int              GLYPH_H      = FONT_GLYPH_H,
    parameter int              SCALE_LOG2   = 1,
    parameter int              X0           = 192,
    parameter int              Y0           = 176,
    parameter int              LZ_SUPPRESS  = 1,
    parameter int              BLINK_FRAMES = 30,
    parameter logic [11:0]     FG_COLOR     = 12'h000,
    parameter logic [11:0]     HL_COLOR     = 12'h00F
) (
    input  logic                        vga_clk,
    input  logic                        vga_rst,
    input  logic [9:0]                  x_pos,
    input  logic [9:0]                  y_pos,
    input  logic [11:0]                 bg_pixel,
    input  logic [4*N_DIGITS-1:0]       digits,
    input  logic [N_DIGITS-1:0]         digit_en,
    input  logic                        sel_valid,
    input  logic [$clog2(N_DIGITS)-1:0] sel_idx,
    output logic [FONT_AW-1:0]          font_addr,
    input  logic                        font_bit,
    output logic [11:0]                 pixel_data
);

    localparam int CW         = GLYPH_W << SCALE_LOG2;
    localparam int CH         = GLYPH_H << SCALE_LOG2;
    localparam int ROW_STRIDE = 10 * GLYPH_W;
    localparam int CMP_W      = 16;
    localparam int CNT_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int SEL_W      = $clog2(N_DIGITS);

    function automatic int cellLeft(input int i);
        return X0 + (N_DIGITS - 1 - i) * CW;
    endfunction

    logic                   frameStart;
    logic [4*N_DIGITS-1:0]  shDigits_q, shDigits_d;
    logic [N_DIGITS-1:0]    shEn_q, shEn_d;
    logic                   shSelValid_q, shSelValid_d;
    logic [SEL_W-1:0]       shSelIdx_q, shSelIdx_d;
    logic [CNT_W-1:0]       blinkCnt_q, blinkCnt_d;
    logic                   blinkPhase_q, blinkPhase_d;

    logic [N_DIGITS-1:0]    blankVec;
    logic [CMP_W-1:0]       xExt, yExt;
    logic [N_DIGITS-1:0]    inColumn;
    logic                   inRows;

    logic                   hit;
    logic [3:0]             cellNib;
    logic                   cellBlank;
    logic                   cellHl;
    logic [CMP_W-1:0]       relX, relY;
    logic [CMP_W-1:0]       gx, gy;

    logic [FONT_AW-1:0]     fontAddr_q, fontAddr_d;
    overlay_flags_t         s1_q, s1_d;
    overlay_flags_t         s2_q;
    logic [11:0]            pixel_q, pixel_d;

    assign frameStart = (x_pos == 10'd0) && (y_pos == 10'd0);

    // Next shadow and blink state; the _d values double as the render view so (0,0) already sees the new frame.
    always_comb begin
        shDigits_d   = shDigits_q;
        shEn_d       = shEn_q;
        shSelValid_d = shSelValid_q;
        shSelIdx_d   = shSelIdx_q;
        blinkCnt_d   = blinkCnt_q;
        blinkPhase_d = blinkPhase_q;
        if (frameStart) begin
            shDigits_d   = digits;
            shEn_d       = digit_en;
            shSelValid_d = sel_valid;
            shSelIdx_d   = sel_idx;
            if (blinkCnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                blinkCnt_d   = '0;
                blinkPhase_d = !blinkPhase_q;
            end else begin
                blinkCnt_d = blinkCnt_q + 1'b1;
            end
        end
    end

    // Frame-latched operands and blink state.
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            shDigits_q   <= '0;
            shEn_q       <= '0;
            shSelValid_q <= 1'b0;
            shSelIdx_q   <= '0;
            blinkCnt_q   <= '0;
            blinkPhase_q <= 1'b0;
        end else begin
            shDigits_q   <= shDigits_d;
            shEn_q       <= shEn_d;
            shSelValid_q <= shSelValid_d;
            shSelIdx_q   <= shSelIdx_d;
            blinkCnt_q   <= blinkCnt_d;
            blinkPhase_q <= blinkPhase_d;
        end
    end

    digit_blank_mask #(
        .N_DIGITS    (N_DIGITS),
        .LZ_SUPPRESS (LZ_SUPPRESS)
    ) u_blank (
        .digits_i   (shDigits_d),
        .digit_en_i (shEn_d),
        .blank_o    (blankVec)
    );

    assign xExt = CMP_W'(x_pos);
    assign yExt = CMP_W'(y_pos);

    // One range comparator per cell column plus a shared row check.
    always_comb begin
        inColumn = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            inColumn[i] = (xExt >= CMP_W'(cellLeft(i))) && (xExt < CMP_W'(cellLeft(i) + CW));
        end
        inRows = (yExt >= CMP_W'(Y0)) && (yExt < CMP_W'(Y0 + CH));
    end

    // Cells are disjoint, so at most one column hits; pick its operands and offset.
    always_comb begin
        hit       = 1'b0;
        cellNib   = '0;
        cellBlank = 1'b0;
        cellHl    = 1'b0;
        relX      = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (inColumn[i] && inRows) begin
                hit       = 1'b1;
                cellNib   = shDigits_d[4*i +: 4];
                cellBlank = blankVec[i];
                cellHl    = shSelValid_d && (int'(shSelIdx_d) == i) && blinkPhase_d;
                relX      = xExt - CMP_W'(cellLeft(i));
            end
        end
        relY = yExt - CMP_W'(Y0);
        gx   = relX >> SCALE_LOG2;
        gy   = relY >> SCALE_LOG2;
    end

    // Stage-1 inputs: ROM address for drawn cells only, plus the flags travelling with the pixel.
    always_comb begin
        fontAddr_d = '0;
        if (hit && !cellBlank) begin
            fontAddr_d = FONT_AW'(int'(cellNib) * GLYPH_W + int'(gx) + int'(gy) * ROW_STRIDE);
        end
        s1_d.inCell = hit;
        s1_d.blank  = cellBlank;
        s1_d.hl     = cellHl;
        s1_d.bg     = bg_pixel;
    end

    // Final colour choice once the ROM bit for this pixel has arrived.
    always_comb begin
        pixel_d = s2_q.bg;
        if (s2_q.inCell && !s2_q.blank && font_bit) begin
            pixel_d = s2_q.hl ? HL_COLOR : FG_COLOR;
        end
    end

    // Three-stage pixel pipeline: address/flags, ROM wait, compose.
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            fontAddr_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            pixel_q    <= '0;
        end else begin
            fontAddr_q <= fontAddr_d;
            s1_q       <= s1_d;
            s2_q       <= s1_q;
            pixel_q    <= pixel_d;
        end
    end

    assign font_addr  = fontAddr_q;
    assign pixel_data = pixel_q;

endmodule

// File: doc/vga_digit_overlay.md
# vga_digit_overlay

Parametrised N-digit numeric overlay for the VGA page renderers. From the scan position it draws a row of scaled 7-segment-style glyphs from the shared number-font ROM over an upstream background pixel. Adds leading-zero suppression, per-digit enable, a blinking selection highlight and frame-latched operands. It sits between a page's background generator and the VGA output register.

## Interface
- N_DIGITS, 4, number of digit cells; digit 0 is least significant and rightmost.
- GLYPH_W, 32, glyph width in ROM pixels.
- GLYPH_H, 64, glyph height in ROM pixels.
- SCALE_LOG2, 1, on-screen magnification is 2^SCALE_LOG2.
- X0, 192, left edge of the overlay box in pixels.
- Y0, 176, top edge of the overlay box in pixels.
- LZ_SUPPRESS, 1, blank leading zeros when set.
- BLINK_FRAMES, 30, number of frames per blink phase; must be ≥1.
- FG_COLOR, 12'h000, glyph colour.
- HL_COLOR, 12'h00F, highlight colour (blue-green-red nibble order).
- vga_clk  in  1  pixel clock. All logic is on its rising edge.
- vga_rst  in  1  reset, synchronous and active-high.
- x_pos  in  10  scan column, 0–639.
- y_pos  in  10  scan row, 0–479.
- bg_pixel  in  12  upstream pixel for the same (x_pos, y_pos).
- digits  in  4*N_DIGITS  BCD value; nibble i feeds cell i.
- digit_en  in  N_DIGITS  per-cell enable.
- sel_valid  in  1  highlight enable.
- sel_idx  in  $clog2(N_DIGITS)  index of the highlighted cell.
- font_addr  out  15  address to the font ROM. The ROM is external, has 1-cycle synchronous read, and stores glyph b at columns b*GLYPH_W and up in a 10*GLYPH_W-wide image.
- font_bit  in  1  ROM data; 1 means glyph foreground.
- pixel_data  out  12  composed pixel.

## Operation
- **Frame latch:** the block samples `digits`, `digit_en`, `sel_valid` and `sel_idx` into shadow registers only on the cycle where x_pos==0 and y_pos==0. All rendering uses the shadow registers.
- **Cell geometry:**
  - CW = GLYPH_W<<SCALE_LOG2; CH = GLYPH_H<<SCALE_LOG2.
  - Cell i spans x in [X0+(N_DIGITS-1-i)*CW, +CW) and y in [Y0, Y0+CH).
  - Cell membership is decided by N parallel comparators; no divider.
- **Glyph addressing:**
  - gx = (x − cell_left)>>SCALE_LOG2; gy = (y − Y0)>>SCALE_LOG2.
  - font_addr = bcd*GLYPH_W + gx + gy*10*GLYPH_W.
- **Blank cell:** a cell is blank if any of these holds:
  - digit_en[i]=0;
  - its nibble is greater than 9;
  - LZ_SUPPRESS=1, i>0, and every nibble at index ≥i is 0 (cell 0 is never LZ-blanked).
  - For a blank cell, pixel_data = bg_pixel and font_addr is driven to 0.
- **Compose:** inside a non-blank cell with font_bit=1, the output is FG_COLOR. Exception: if sel_valid=1, the cell index equals sel_idx, and blink_phase=1, the output is HL_COLOR. In every other case the output is bg_pixel.
- **Blink counter:**
  - The counter advances on each frame-latch cycle and wraps at BLINK_FRAMES-1.
  - blink_phase toggles on each wrap.
- **Out-of-range selection:** if sel_idx ≥ N_DIGITS, no cell is highlighted.

## Timing
- **Stage 1 (edge t+1, inputs sampled at edge t):**
  - registers font_addr, in_cell, blank and hl flags;
  - delays bg_pixel.
- **Stage 2 (edge t+2):** the ROM returns font_bit; the flags and bg_pixel are delayed once more.
- **Stage 3 (edge t+3):** pixel_data is registered. The latency from x_pos/y_pos/bg_pixel to pixel_data is exactly 3 cycles. The sync generator delays hsync/vsync to match.
- **Frame-latch timing:** the shadow registers update at the edge that samples (0,0). The first pixel of that frame already uses the new values.
- **Reset values:** pixel_data=0, font_addr=0, every pipeline flag=0, every shadow register=0, blink counter=0, blink_phase=0.
- **Reset mid-frame:** outputs are zero for every cycle in which vga_rst is sampled high. Normal output resumes 3 cycles after release; the shadow registers stay 0 until the next (0,0).

## Structure
- **Shared package (vga_pkg):**
  - screen size constants (640, 480);
  - 12-bit colour constants;
  - font ROM geometry: GLYPH_W, GLYPH_H, ROM row stride 320, 15-bit address width.
- **Sub-module:** `digit_blank_mask` is a combinational sub-module. It takes the digits, enables and LZ_SUPPRESS and produces the N-bit blank vector; it is evaluated on the shadow registers.

## Test plan
All scenarios use the defaults (N_DIGITS=4, X0=192, Y0=176, SCALE_LOG2=1) with a behavioural 1-cycle ROM.
1. Assert vga_rst for 2 cycles mid-line with bg_pixel=12'hABC → pixel_data=0 and font_addr=0 on the following edges. Pixel_data=12'hABC resumes 3 cycles after release.
2. Latch digits=16'h0007, digit_en=4'hF, LZ=1:
   - (384,176) → font_addr=224 one edge later;
   - (447,303) → font_addr=20415;
   - (383,176) → cell 1 is blank, so pixel_data=bg_pixel.
3. bg_pixel=12'h123 at (10,10) → pixel_data=12'h123 exactly 3 edges later. Inside cell 0 with font_bit=1 → 12'h000.
4. digits=16'h0050 → cells 3 and 2 show bg, cells 1 and 0 render. digits=16'h0000 → only cell 0 renders. digits=16'h00B0 → cell 1 is blank.
5. Change digits from 16'h0001 to 16'h0009 at y=200 → font_addr still uses glyph 1 until (0,0) of the next frame, then uses glyph 9.
6. BLINK_FRAMES=2, sel_valid=1, sel_idx=2 → glyph pixels of cell 2 alternate FG_COLOR/HL_COLOR every 2 frames. Cells 0, 1 and 3 stay FG_COLOR.
